pcint_flag_ctrl: RTL and testbench

Input-side companion of the Port E pin logic: synchronizes the four Port E pads, produces the synchronized PINE value consumed by the port, detects masked logic changes on PCINT[27:24], and owns the PCIFR register (IO 0x1B). It holds all four pin-change flags. Port E sets PCIF3 internally, and the other port blocks set PCIF2..0 by pulse. It raises a level interrupt request to the interrupt controller and clears a flag on vector acknowledge or on a CPU write-one.

---
 rtl/pcint_flag_ctrl.sv | 115 +++++++++++
 tb/tb_pcint_flag_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcint_flag_ctrl.sv
// pcint_flag_ctrl
//   Input side of the Port E pin logic. Synchronizes the Port E pads and
//   detects masked pin changes on PCINT[27:24]. Owns PCIFR (PCIF[3:0]) and
//   raises a level interrupt request for each enabled flag.
//
// Ports
//   cp2, ireset        clock (rising edge) and asynchronous active-low reset
//   IO_Addr, iore,     IO bus; PCIFR reads combinationally and is
//   iowe, dbus_in,     write-one-to-clear
//   dbus_out, out_en
//   pad_i, din_dis_i   raw pad levels, per-pad digital-input disable
//   pcmsk_i, pcie_i    change-enable mask (PCMSK3), interrupt enables (PCICR)
//   pcif_set_i         set pulses for PCIF2..0 from the other ports
//   irq_ack_i          vector acknowledge per flag
//   pin_sync_o         synchronized pads (PINE read path)
//   pcif_o, irq_o      flags and interrupt requests
module pcint_flag_ctrl #(
    parameter int unsigned port_width    = 4,
    parameter logic [5:0]  PCIFR_Address = 6'h1b,
    parameter int unsigned sync_stages   = 2
) (
    input  logic                  cp2,
    input  logic                  ireset,
    input  logic [5:0]            IO_Addr,
    input  logic                  iore,
    input  logic                  iowe,
    input  logic [7:0]            dbus_in,
    output logic [7:0]            dbus_out,
    output logic                  out_en,
    input  logic [port_width-1:0] pad_i,
    input  logic [port_width-1:0] din_dis_i,
    input  logic [port_width-1:0] pcmsk_i,
    input  logic [3:0]            pcie_i,
    input  logic [2:0]            pcif_set_i,
    input  logic [3:0]            irq_ack_i,
    output logic [port_width-1:0] pin_sync_o,
    output logic [3:0]            pcif_o,
    output logic [3:0]            irq_o
);

    // Wide enough to hold sync_stages+1 (2 bits for the default depth).
    localparam int unsigned   CntW   = $clog2(sync_stages + 2);
    localparam logic [CntW-1:0] ArmVal = CntW'(sync_stages + 1);

    logic [port_width-1:0] sync_q [sync_stages];
    logic [port_width-1:0] sync_d [sync_stages];
    logic [port_width-1:0] prev_q, prev_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [3:0]            pcif_q, pcif_d;

    logic                  armed;
    logic [port_width-1:0] chg;
    logic                  pcifr_sel;
    logic                  pcifr_wr;
    logic [3:0]            pcif_set;
    logic [3:0]            pcif_clr;
    logic                  unused_dbus;

    assign unused_dbus = ^dbus_in[7:4];

    assign pin_sync_o = sync_q[sync_stages-1];
    assign armed      = (cnt_q == ArmVal);
    // Until armed, the levels present at reset release must not look like changes.
    assign chg        = (pin_sync_o ^ prev_q) & pcmsk_i & {port_width{armed}};

    assign pcifr_sel = (IO_Addr == PCIFR_Address);
    assign pcifr_wr  = iowe & pcifr_sel;

    always_comb begin
        sync_d[0] = pad_i & ~din_dis_i;
        for (int i = 1; i < int'(sync_stages); i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = pin_sync_o;
        cnt_d  = armed ? cnt_q : cnt_q + 1'b1;
    end

    always_comb begin
        pcif_set = {|chg, pcif_set_i};
        pcif_clr = irq_ack_i | ({4{pcifr_wr}} & dbus_in[3:0]);
        // Set wins over a clear arriving in the same cycle.
        pcif_d   = pcif_set | (pcif_q & ~pcif_clr);
    end

    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            for (int i = 0; i < int'(sync_stages); i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
            cnt_q  <= '0;
            pcif_q <= '0;
        end else begin
            for (int i = 0; i < int'(sync_stages); i++) begin
                sync_q[i] <= sync_d[i];
            end
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
            pcif_q <= pcif_d;
        end
    end

    always_comb begin
        out_en   = 1'b0;
        dbus_out = 8'h00;
        if (iore && pcifr_sel) begin
            out_en   = 1'b1;
            dbus_out = {4'b0000, pcif_q};
        end
    end

    assign pcif_o = pcif_q;
    assign irq_o  = pcif_q & pcie_i;

endmodule

// File: tb/tb_pcint_flag_ctrl.sv
// Directed bench for pcint_flag_ctrl. Expected values are queued when the
// stimulus is applied and popped when the matching output is sampled.
module tb_pcint_flag_ctrl;

    logic       cp2;
    logic       ireset;
    logic [5:0] IO_Addr;
    logic       iore;
    logic       iowe;
    logic [7:0] dbus_in;
    logic [7:0] dbus_out;
    logic       out_en;
    logic [3:0] pad_i;
    logic [3:0] din_dis_i;
    logic [3:0] pcmsk_i;
    logic [3:0] pcie_i;
    logic [2:0] pcif_set_i;
    logic [3:0] irq_ack_i;
    logic [3:0] pin_sync_o;
    logic [3:0] pcif_o;
    logic [3:0] irq_o;

    pcint_flag_ctrl dut (
        .cp2        (cp2),
        .ireset     (ireset),
        .IO_Addr    (IO_Addr),
        .iore       (iore),
        .iowe       (iowe),
        .dbus_in    (dbus_in),
        .dbus_out   (dbus_out),
        .out_en     (out_en),
        .pad_i      (pad_i),
        .din_dis_i  (din_dis_i),
        .pcmsk_i    (pcmsk_i),
        .pcie_i     (pcie_i),
        .pcif_set_i (pcif_set_i),
        .irq_ack_i  (irq_ack_i),
        .pin_sync_o (pin_sync_o),
        .pcif_o     (pcif_o),
        .irq_o      (irq_o)
    );

    initial cp2 = 1'b0;
    always #5 cp2 = ~cp2;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic push(input string tag, input logic [7:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input logic [7:0] obs);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed=%h required=<queued value>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s: observed=%h required=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge cp2);
            #1;
        end
    endtask

    task automatic io_write(input logic [7:0] data);
        IO_Addr = 6'h1b;
        dbus_in = data;
        iowe    = 1'b1;
        tick(1);
        iowe    = 1'b0;
        dbus_in = 8'h00;
    endtask

    initial begin
        ireset     = 1'b0;
        IO_Addr    = 6'h00;
        iore       = 1'b0;
        iowe       = 1'b0;
        dbus_in    = 8'h00;
        pad_i      = 4'hF;
        din_dis_i  = 4'h0;
        pcmsk_i    = 4'hF;
        pcie_i     = 4'h8;
        pcif_set_i = 3'b000;
        irq_ack_i  = 4'h0;

        // Reset state
        push("rst_pin_sync", 8'h00);
        push("rst_pcif", 8'h00);
        push("rst_irq", 8'h00);
        push("rst_out_en", 8'h00);
        push("rst_dbus_out", 8'h00);
        #3;
        pop_check({4'h0, pin_sync_o});
        pop_check({4'h0, pcif_o});
        pop_check({4'h0, irq_o});
        pop_check({7'h0, out_en});
        pop_check(dbus_out);

        // Release with pads high: synchronized after 2 edges, no spurious flag
        @(posedge cp2);
        #1;
        ireset = 1'b1;
        push("release_pin_sync", 8'h0F);
        tick(2);
        pop_check({4'h0, pin_sync_o});
        for (int i = 0; i < 20; i++) begin
            push("guard_pcif", 8'h00);
            push("guard_irq", 8'h00);
            tick(1);
            pop_check({4'h0, pcif_o});
            pop_check({4'h0, irq_o});
        end

        // Masked rise on pad 2: 3-edge latency
        pcmsk_i = 4'h0;
        pad_i   = 4'b1011;
        tick(3);
        pcmsk_i = 4'b0100;
        pad_i   = 4'b1111;
        tick(1);
        push("e1_pin_sync", 8'h0F);
        push("e1_pcif", 8'h00);
        tick(1);
        pop_check({4'h0, pin_sync_o});
        pop_check({4'h0, pcif_o});
        push("e2_pcif", 8'h08);
        push("e2_irq", 8'h08);
        tick(1);
        pop_check({4'h0, pcif_o});
        pop_check({4'h0, irq_o});

        // Read PCIFR, then a read at another address
        IO_Addr = 6'h1b;
        iore    = 1'b1;
        push("rd_out_en", 8'h01);
        push("rd_dbus_out", 8'h08);
        #1;
        pop_check({7'h0, out_en});
        pop_check(dbus_out);
        IO_Addr = 6'h1a;
        push("rd_other_out_en", 8'h00);
        push("rd_other_dbus_out", 8'h00);
        #1;
        pop_check({7'h0, out_en});
        pop_check(dbus_out);
        iore = 1'b0;

        // Write 0 has no effect; write 1 clears
        push("wr0_pcif", 8'h08);
        io_write(8'h00);
        pop_check({4'h0, pcif_o});
        push("wr1_pcif", 8'h00);
        push("wr1_irq", 8'h00);
        io_write(8'hF8);
        pop_check({4'h0, pcif_o});
        pop_check({4'h0, irq_o});

        // Unmasked pad 0 toggling leaves the flag clear
        for (int i = 0; i < 4; i++) begin
            pad_i[0] = ~pad_i[0];
            tick(1);
        end
        push("unmasked_pcif", 8'h00);
        tick(4);
        pop_check({4'h0, pcif_o});

        // Set the flag again, then ack coinciding with a new change
        pad_i = 4'b1011;
        push("fall_pcif", 8'h08);
        tick(3);
        pop_check({4'h0, pcif_o});
        pad_i = 4'b1111;
        tick(2);
        irq_ack_i = 4'b1000;
        push("ack_vs_chg_pcif", 8'h08);
        tick(1);
        irq_ack_i = 4'h0;
        pop_check({4'h0, pcif_o});
        push("hold_pcif", 8'h08);
        tick(1);
        pop_check({4'h0, pcif_o});
        irq_ack_i = 4'b1000;
        push("ack_pcif", 8'h00);
        tick(1);
        irq_ack_i = 4'h0;
        pop_check({4'h0, pcif_o});

        // Set pulses from the other ports, gated interrupt requests
        pcie_i     = 4'b0001;
        pcif_set_i = 3'b101;
        push("set_pcif", 8'h05);
        push("set_irq", 8'h01);
        tick(1);
        pcif_set_i = 3'b000;
        pop_check({4'h0, pcif_o});
        pop_check({4'h0, irq_o});
        push("wr05_pcif", 8'h00);
        io_write(8'h05);
        pop_check({4'h0, pcif_o});

        // Set beats a same-cycle write-one clear
        pcif_set_i = 3'b001;
        push("set_vs_wr_pcif", 8'h01);
        io_write(8'h01);
        pcif_set_i = 3'b000;
        pop_check({4'h0, pcif_o});
        push("wr01_pcif", 8'h00);
        io_write(8'h01);
        pop_check({4'h0, pcif_o});

        // Digital-input disable forces the synchronizer input low
        pcmsk_i   = 4'h0;
        din_dis_i = 4'b0010;
        push("din_dis_pin_sync", 8'h0D);
        tick(3);
        pop_check({4'h0, pin_sync_o});
        pcmsk_i = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            pad_i[1] = ~pad_i[1];
            push("din_dis_toggle_pin_sync", 8'h0D);
            tick(1);
            pop_check({4'h0, pin_sync_o});
        end
        push("din_dis_pcif", 8'h00);
        tick(3);
        pop_check({4'h0, pcif_o});

        // Asynchronous reset while a flag is pending
        pcmsk_i    = 4'h0;
        pcie_i     = 4'hF;
        pcif_set_i = 3'b100;
        push("pre_rst_pcif", 8'h04);
        push("pre_rst_irq", 8'h04);
        tick(1);
        pcif_set_i = 3'b000;
        pop_check({4'h0, pcif_o});
        pop_check({4'h0, irq_o});
        #2;
        ireset = 1'b0;
        push("mid_rst_pin_sync", 8'h00);
        push("mid_rst_pcif", 8'h00);
        push("mid_rst_irq", 8'h00);
        push("mid_rst_out_en", 8'h00);
        push("mid_rst_dbus_out", 8'h00);
        #1;
        pop_check({4'h0, pin_sync_o});
        pop_check({4'h0, pcif_o});
        pop_check({4'h0, irq_o});
        pop_check({7'h0, out_en});
        pop_check(dbus_out);

        // Guard reruns after the second release
        @(posedge cp2);
        #1;
        din_dis_i = 4'h0;
        pcmsk_i   = 4'hF;
        ireset    = 1'b1;
        push("rerelease_pin_sync", 8'h0F);
        tick(2);
        pop_check({4'h0, pin_sync_o});
        for (int i = 0; i < 20; i++) begin
            push("reguard_pcif", 8'h00);
            tick(1);
            pop_check({4'h0, pcif_o});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
